// File: rtl/dmem_pkg.sv
// Shared types for the pipelined data memory.
//   dm_ctrl_e    : load/store size and extension encoding from the MEM stage
//   dmem_state_e : request FSM states
//   is_legal()   : rejects reserved encodings and stores with an unsigned size
package dmem_pkg;

  typedef enum logic [2:0] {
    DM_B  = 3'b000,
    DM_H  = 3'b001,
    DM_W  = 3'b010,
    DM_BU = 3'b100,
    DM_HU = 3'b101
  } dm_ctrl_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } dmem_state_e;

  function automatic logic is_legal(input logic [2:0] dm_ctrl, input logic we);
    case (dm_ctrl)
      DM_B, DM_H, DM_W: is_legal = 1'b1;
      DM_BU, DM_HU:     is_legal = !we;
      default:          is_legal = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane alignment for the data memory (purely combinational).
//   off, ctrl   : byte offset within the word and dm_ctrl encoding
//   wdata       : right-aligned store data
//   strb        : byte-lane write strobe
//   wdata_lane  : store data replicated onto every lane it may land on
//   word        : 32-bit word read from the array
//   rdata       : extracted and sign/zero-extended load result
//   misaligned  : access does not fit its natural alignment
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]  off,
  input  logic [2:0]  ctrl,
  input  logic [31:0] wdata,
  input  logic [31:0] word,
  output logic [3:0]  strb,
  output logic [31:0] wdata_lane,
  output logic [31:0] rdata,
  output logic        misaligned
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    shifted    = word >> {off, 3'b000};
    byte_sel   = shifted[7:0];
    half_sel   = off[1] ? word[31:16] : word[15:0];
    strb       = 4'b0000;
    wdata_lane = wdata;
    rdata      = 32'd0;
    misaligned = 1'b0;
    case (ctrl)
      DM_B, DM_BU: begin
        strb       = 4'b0001 << off;
        wdata_lane = {4{wdata[7:0]}};
        rdata      = ctrl[2] ? {24'd0, byte_sel} : {{24{byte_sel[7]}}, byte_sel};
      end
      DM_H, DM_HU: begin
        strb       = off[1] ? 4'b1100 : 4'b0011;
        wdata_lane = {2{wdata[15:0]}};
        rdata      = ctrl[2] ? {16'd0, half_sel} : {{16{half_sel[15]}}, half_sel};
        misaligned = off[0];
      end
      DM_W: begin
        strb       = 4'b1111;
        rdata      = word;
        misaligned = |off;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/data_memory_pipelined.sv
// RV32 data memory with a valid/ready request port and configurable read latency.
//   clk, rst      : clock and asynchronous active-high reset
//   req_*         : request handshake, store flag, byte address, store data, dm_ctrl
//   rsp_valid     : one-cycle response pulse (no backpressure)
//   rsp_rdata     : extended load data, 0 for stores and faults
//   rsp_fault     : request rejected (misaligned, out of range or illegal)
//
// state | meaning
// IDLE  | nothing outstanding, ready for a request
// WAIT  | load accepted, counting down the remaining read latency
// RESP  | response presented this cycle; a new request may be accepted
module data_memory_pipelined
  import dmem_pkg::*;
#(
  parameter int    DEPTH_WORDS  = 256,
  parameter int    READ_LATENCY = 1,
  parameter string INIT_FILE    = ""
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic [2:0]  req_dm_ctrl,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault
);

  localparam int         IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = (READ_LATENCY > 1) ? 2'(READ_LATENCY - 2) : 2'd0;

  logic [31:0] mem [DEPTH_WORDS];

  dmem_state_e state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] word_q;
  logic [1:0]  off_q;
  logic [2:0]  ctrl_q;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic             accept;
  logic             out_of_range;
  logic             req_fault;
  logic             load_done;
  logic [IDX_W-1:0] req_idx;
  logic [31:0]      al_word;
  logic [1:0]       al_off;
  logic [2:0]       al_ctrl;
  logic [3:0]       st_strb;
  logic [31:0]      st_data;
  logic [31:0]      ld_data;
  logic             misaligned;

  assign req_ready    = ((state_q == IDLE) || (state_q == RESP)) && !rst;
  assign accept       = req_valid && req_ready;
  assign req_idx      = req_addr[IDX_W+1:2];
  assign out_of_range = {2'b00, req_addr[31:2]} >= 32'(DEPTH_WORDS);

  // Outside WAIT the aligner looks at the live request, so a latency-1 load and
  // the misalignment check use the current address; in WAIT it replays the
  // word and offset captured at acceptance.
  assign al_word = (state_q == WAIT) ? word_q : mem[req_idx];
  assign al_off  = (state_q == WAIT) ? off_q  : req_addr[1:0];
  assign al_ctrl = (state_q == WAIT) ? ctrl_q : req_dm_ctrl;

  dmem_lane_align u_align (
    .off        (al_off),
    .ctrl       (al_ctrl),
    .wdata      (req_wdata),
    .word       (al_word),
    .strb       (st_strb),
    .wdata_lane (st_data),
    .rdata      (ld_data),
    .misaligned (misaligned)
  );

  assign req_fault = misaligned || out_of_range || !is_legal(req_dm_ctrl, req_we);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE, RESP: begin
        state_d = IDLE;
        if (accept) begin
          if (req_fault || req_we || (READ_LATENCY == 1)) begin
            state_d = RESP;
          end else begin
            state_d = WAIT;
            cnt_d   = CNT_INIT;
          end
        end
      end
      WAIT: begin
        if (cnt_q == 2'd0) state_d = RESP;
        else               cnt_d   = cnt_q - 2'd1;
      end
      default: state_d = IDLE;
    endcase
  end

  // Response payload is registered on entry to RESP and forced to zero otherwise.
  always_comb begin
    load_done = (state_q == WAIT) || (accept && !req_fault && !req_we);
    rdata_d   = ((state_d == RESP) && load_done) ? ld_data : 32'd0;
    fault_d   = (state_d == RESP) && accept && req_fault;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 2'd0;
      word_q  <= 32'd0;
      off_q   <= 2'd0;
      ctrl_q  <= 3'd0;
      rdata_q <= 32'd0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
      if (accept) begin
        word_q <= mem[req_idx];
        off_q  <= req_addr[1:0];
        ctrl_q <= req_dm_ctrl;
      end
    end
  end

  // Array is not reset; only accepted, non-faulting stores write it.
  always_ff @(posedge clk) begin
    if (accept && req_we && !req_fault) begin
      for (int i = 0; i < 4; i++) begin
        if (st_strb[i]) mem[req_idx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  assign rsp_valid = (state_q == RESP);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;

endmodule
